// File: rtl/fabric_spi_flash_responder.sv
// SPI mode-0 target serving READ (0x03) + 24-bit address from a synchronous word memory.
// All SPI pins are oversampled in the clk_i domain; edges come from the synchronised sclk.
module fabric_spi_flash_responder #(
  parameter int          MEM_AW   = 10,
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter int          SYNC_FF  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_ni,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              mem_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  logic [SYNC_FF-1:0] sclk_sync, cs_sync, mosi_sync;
  logic               sclk_d;
  logic               sclk_s, cs_s, mosi_s, rise, fall;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [23:0] shreg, addr;
  logic [31:0] wbuf;
  logic        rd_pend;
  logic [6:0]  tx_sh;
  logic [2:0]  tx_cnt;

  logic [23:0] shift_in, addr_inc;
  logic [31:0] word_src;
  logic [7:0]  byte_sel;

  assign sclk_s = sclk_sync[SYNC_FF-1];
  assign cs_s   = cs_sync[SYNC_FF-1];
  assign mosi_s = mosi_sync[SYNC_FF-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_FF-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_FF-2:0], cs_ni};
      mosi_sync <= {mosi_sync[SYNC_FF-2:0], mosi_i};
      sclk_d    <= sclk_s;
    end
  end

  // The first word can land on the same cycle as the first fall, so bypass the buffer.
  always_comb begin
    shift_in = {shreg[22:0], mosi_s};
    addr_inc = addr + 24'd1;
    word_src = rd_pend ? mem_rdata_i : wbuf;
    byte_sel = 8'h00;
    case (addr[1:0])
      2'd0: byte_sel = word_src[31:24];
      2'd1: byte_sel = word_src[23:16];
      2'd2: byte_sel = word_src[15:8];
      2'd3: byte_sel = word_src[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      addr       <= '0;
      wbuf       <= '0;
      rd_pend    <= 1'b0;
      tx_sh      <= '0;
      tx_cnt     <= '0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      mem_en_o <= 1'b0;
      rd_pend  <= mem_en_o;
      busy_o   <= ~cs_s;
      if (rd_pend) wbuf <= mem_rdata_i;
      if (cs_s) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        tx_cnt    <= '0;
        miso_o    <= 1'b0;
        miso_oe_o <= 1'b0;
        rd_pend   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            shreg <= shift_in;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              state   <= (shift_in[7:0] == READ_CMD) ? ADDR : IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ADDR: if (rise) begin
            shreg <= shift_in;
            if (bit_cnt == 5'd23) begin
              addr       <= shift_in;
              mem_en_o   <= 1'b1;
              mem_addr_o <= shift_in[MEM_AW+1:2];
              miso_oe_o  <= 1'b1;
              tx_cnt     <= '0;
              state      <= DATA;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          DATA: if (fall) begin
            if (tx_cnt == 3'd0) begin
              miso_o <= byte_sel[7];
              tx_sh  <= byte_sel[6:0];
              // Last byte of the word is now in the shifter: fetch the next word.
              if (addr[1:0] == 2'd3) begin
                mem_en_o   <= 1'b1;
                mem_addr_o <= addr_inc[MEM_AW+1:2];
              end
            end else begin
              miso_o <= tx_sh[6];
              tx_sh  <= {tx_sh[5:0], 1'b0};
            end
            tx_cnt <= tx_cnt + 3'd1;
            if (tx_cnt == 3'd7) addr <= addr_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fabric_spi_flash_responder.sv
// Directed bench: SPI controller tasks drive the responder against a 1-cycle-latency memory model.
module tb_fabric_spi_flash_responder;
  logic        clk = 1'b0;
  logic        rst, sclk, cs_n, mosi;
  logic        miso, miso_oe, mem_en, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  logic [7:0]  rxb [0:63];
  logic [7:0]  junk;
  logic [9:0]  en_addr [0:15];
  int          en_cnt, dbl, miso_bad, oe_seen, prev_en;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  fabric_spi_flash_responder #(.MEM_AW(10), .READ_CMD(8'h03), .SYNC_FF(2)) dut (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_ni(cs_n), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .mem_en_o(mem_en), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (mem_en) begin
      if (en_cnt < 16) en_addr[en_cnt] = mem_addr;
      en_cnt = en_cnt + 1;
      if (prev_en != 0) dbl = dbl + 1;
    end
    prev_en = int'(mem_en);
    if (miso_oe) oe_seen = 1;
    if (!miso_oe && miso) miso_bad = miso_bad + 1;
  end

  task automatic clr_mon;
    en_cnt = 0; oe_seen = 0;
  endtask

  task automatic spi_begin;
    cs_n = 1'b0;
    #80;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #80;
      rx[i] = miso;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end;
    #80;
    cs_n = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    @(negedge clk);
    spi_begin();
    spi_bits(8'h03, 8, junk);
    spi_bits(a[23:16], 8, junk);
    spi_bits(a[15:8], 8, junk);
    spi_bits(a[7:0], 8, junk);
    for (int k = 0; k < n; k++) spi_bits(8'h00, 8, rxb[k]);
    spi_end();
  endtask

  task automatic test_reset;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (miso_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe got=%b exp=0", miso_oe); end
    checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL reset_en got=%b exp=0", mem_en); end
    checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_aligned;
    logic [7:0] exp [0:7];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    clr_mon();
    spi_read(24'h000000, 8);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rxb[k] !== exp[k]) begin errors++; $display("FAIL aligned_byte%0d got=%h exp=%h", k, rxb[k], exp[k]); end
    end
    // Loading byte 7 (offset 3) already prefetches word 2.
    checks++; if (en_cnt !== 3) begin errors++; $display("FAIL aligned_en_cnt got=%0d exp=3", en_cnt); end
    checks++; if (en_addr[0] !== 10'd0) begin errors++; $display("FAIL aligned_en0 got=%0d exp=0", en_addr[0]); end
    checks++; if (en_addr[1] !== 10'd1) begin errors++; $display("FAIL aligned_en1 got=%0d exp=1", en_addr[1]); end
    checks++; if (en_addr[2] !== 10'd2) begin errors++; $display("FAIL aligned_en2 got=%0d exp=2", en_addr[2]); end
  endtask

  task automatic test_read_offset;
    logic [7:0] exp [0:2];
    exp = '{8'hBE, 8'hEF, 8'h01};
    clr_mon();
    spi_read(24'h000002, 3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rxb[k] !== exp[k]) begin errors++; $display("FAIL offset_byte%0d got=%h exp=%h", k, rxb[k], exp[k]); end
    end
    checks++; if (en_cnt !== 2) begin errors++; $display("FAIL offset_en_cnt got=%0d exp=2", en_cnt); end
    checks++; if (en_addr[0] !== 10'd0) begin errors++; $display("FAIL offset_en0 got=%0d exp=0", en_addr[0]); end
    checks++; if (en_addr[1] !== 10'd1) begin errors++; $display("FAIL offset_en1 got=%0d exp=1", en_addr[1]); end
  endtask

  task automatic test_ignore;
    clr_mon();
    @(negedge clk);
    spi_begin();
    for (int k = 0; k < 5; k++) spi_bits(k == 0 ? 8'h0B : 8'h00, 8, junk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    spi_end();
    checks++; if (oe_seen !== 0) begin errors++; $display("FAIL ignore_oe got=%0d exp=0", oe_seen); end
    checks++; if (en_cnt !== 0)  begin errors++; $display("FAIL ignore_en_cnt got=%0d exp=0", en_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp [0:7];
    exp = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clr_mon();
    spi_read(24'h000FFC, 8);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rxb[k] !== exp[k]) begin errors++; $display("FAIL wrap_byte%0d got=%h exp=%h", k, rxb[k], exp[k]); end
    end
    checks++; if (en_addr[0] !== 10'd1023) begin errors++; $display("FAIL wrap_en0 got=%0d exp=1023", en_addr[0]); end
    checks++; if (en_addr[1] !== 10'd0)    begin errors++; $display("FAIL wrap_en1 got=%0d exp=0", en_addr[1]); end
  endtask

  task automatic test_abort;
    logic [7:0] exp [0:3];
    exp = '{8'h01, 8'h23, 8'h45, 8'h67};
    clr_mon();
    @(negedge clk);
    spi_begin();
    spi_bits(8'h03, 8, junk);
    spi_bits(8'hFF, 8, junk);
    spi_bits(8'hF0, 4, junk);
    spi_end();
    checks++; if (en_cnt !== 0) begin errors++; $display("FAIL abort_en_cnt got=%0d exp=0", en_cnt); end
    spi_read(24'h000004, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rxb[k] !== exp[k]) begin errors++; $display("FAIL abort_byte%0d got=%h exp=%h", k, rxb[k], exp[k]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [0:3];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    @(negedge clk);
    spi_begin();
    spi_bits(8'h03, 8, junk);
    for (int k = 0; k < 3; k++) spi_bits(8'h00, 8, junk);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h00, 3, junk);
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL rstmid_oe_before got=%b exp=1", miso_oe); end
    #13 rst = 1'b1;
    #1;
    checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
    checks++; if (miso_oe !== 1'b0)  begin errors++; $display("FAIL rstmid_oe got=%b exp=0", miso_oe); end
    checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rstmid_en got=%b exp=0", mem_en); end
    checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL rstmid_addr got=%0d exp=0", mem_addr); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    #20 rst = 1'b0;
    spi_end();
    spi_read(24'h000000, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rxb[k] !== exp[k]) begin errors++; $display("FAIL rstmid_byte%0d got=%h exp=%h", k, rxb[k], exp[k]); end
    end
  endtask

  task automatic test_bitstream_load;
    logic [31:0] got, exp;
    for (int i = 0; i < 10; i++) mem[16+i] = {8'(i), 8'hA5, 8'(i*3), 8'h5A};
    spi_read(24'h000040, 40);
    for (int i = 0; i < 10; i++) begin
      got = {rxb[4*i], rxb[4*i+1], rxb[4*i+2], rxb[4*i+3]};
      exp = {8'(i), 8'hA5, 8'(i*3), 8'h5A};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL load_word%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_protocol;
    checks++; if (dbl !== 0)      begin errors++; $display("FAIL en_back_to_back got=%0d exp=0", dbl); end
    checks++; if (miso_bad !== 0) begin errors++; $display("FAIL miso_without_oe got=%0d exp=0", miso_bad); end
  endtask

  initial begin
    en_cnt = 0; dbl = 0; miso_bad = 0; oe_seen = 0; prev_en = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h01234567;
    mem[1023] = 32'hCAFEF00D;
    mem_rdata = 32'h0;
    test_reset();
    dbl = 0; miso_bad = 0;
    test_read_aligned();
    test_read_offset();
    test_ignore();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_bitstream_load();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
